// File: rtl/delta_seq_pkg.sv
// delta_seq_pkg: shared state type, widths and power-up sample table for the delta frame sequencer
package delta_seq_pkg;
  typedef enum logic [2:0] {IDLE, PACE, ISSUE, RESP, DONE} state_t;
  localparam int SMP_IDX_W = 3;
  localparam int LED_W = 8;
  localparam logic [7:0][7:0] DEF_TABLE = {8'h75, 8'hBD, 8'hB5, 8'hA6, 8'h76, 8'hB5, 8'h9D, 8'h00};
endpackage

// File: rtl/delta_frame_sequencer_if.sv
// delta_frame_sequencer_if: sample handshake to the delta encoder and its one-bit code return
interface delta_frame_sequencer_if #(parameter int DW = 8);
  logic [DW-1:0] smp_data;
  logic smp_valid, smp_ready, bit_in, bit_valid;
  modport master (output smp_data, smp_valid, input smp_ready, bit_in, bit_valid);
  modport slave (input smp_data, smp_valid, output smp_ready, bit_in, bit_valid);
endinterface

// File: rtl/pace_tick.sv
// pace_tick: down-counter that pulses tick on the TICK_DIV-th consecutive cycle without clr
module pace_tick #(parameter int TICK_DIV = 100000) (
  input logic CLK100MHZ,
  input logic CPU_RESETN,
  input logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = ~clr & (cnt == '0);
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) cnt <= '0;
    else cnt <= (clr || tick) ? CW'(TICK_DIV - 1) : cnt - 1'b1;
endmodule

// File: rtl/delta_frame_sequencer.sv
// delta_frame_sequencer: paces the sample table through the delta encoder one sample per tick
// and publishes the returned codes as an LED frame
module delta_frame_sequencer
  import delta_seq_pkg::*;
#(
  parameter int NSAMP = 8,
  parameter int DW = 8,
  parameter int TICK_DIV = 100000,
  parameter int WAIT_MAX = 255
) (
  input logic CLK100MHZ,
  input logic CPU_RESETN,
  input logic start,
  input logic cfg_we,
  input logic [SMP_IDX_W-1:0] cfg_addr,
  input logic [DW-1:0] cfg_data,
  delta_frame_sequencer_if.master bus,
  output logic busy,
  output logic done,
  output logic timeout_err,
  output logic [LED_W-1:0] LED
);
  localparam int TW = $clog2(WAIT_MAX + 1);
  state_t state, nxt;
  logic start_q, start_rise, tick, hs, expire, last;
  logic [SMP_IDX_W-1:0] idx;
  logic [TW-1:0] tcnt;
  logic [LED_W-1:0] frame;
  logic [DW-1:0] tbl [8];
  assign start_rise = start & ~start_q;
  assign hs = bus.smp_valid & bus.smp_ready;
  assign expire = tcnt == TW'(WAIT_MAX - 1);
  assign last = idx == SMP_IDX_W'(NSAMP - 1);
  pace_tick #(.TICK_DIV(TICK_DIV)) u_pace (
    .CLK100MHZ(CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .clr(state != PACE),
    .tick(tick)
  );
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start_rise ? PACE : IDLE;
      PACE: nxt = tick ? ISSUE : PACE;
      ISSUE: nxt = hs ? RESP : ISSUE;
      RESP: nxt = (bus.bit_valid | expire) ? (last ? DONE : PACE) : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      start_q <= 1'b0;
      idx <= '0;
      tcnt <= '0;
      frame <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout_err <= 1'b0;
      LED <= '0;
      bus.smp_valid <= 1'b0;
      bus.smp_data <= '0;
      for (int i = 0; i < 8; i++) tbl[i] <= DW'(DEF_TABLE[i]);
    end else begin
      start_q <= start;
      done <= 1'b0;
      tcnt <= state == RESP ? tcnt + 1'b1 : '0;
      if (state == IDLE && cfg_we && int'(cfg_addr) < NSAMP) tbl[cfg_addr] <= cfg_data;
      if (state == IDLE && start_rise) begin
        idx <= '0;
        frame <= '0;
        timeout_err <= 1'b0;
        busy <= 1'b1;
      end
      // data is captured only while valid is low, so it stays frozen under backpressure
      if (state == ISSUE) begin
        bus.smp_valid <= ~hs;
        if (!bus.smp_valid) bus.smp_data <= tbl[idx];
      end
      if (state == RESP && (bus.bit_valid || expire)) begin
        frame[idx] <= bus.bit_valid & bus.bit_in;
        timeout_err <= timeout_err | ~bus.bit_valid;
        idx <= last ? idx : idx + 1'b1;
      end
      if (state == DONE) begin
        LED <= frame;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_delta_frame_sequencer.sv
// tb_delta_frame_sequencer: randomized scoreboard bench; the reference is the frame rule
// "bit i = MSB of table[i] if its code returned within WAIT_MAX cycles, else 0"
module tb_delta_frame_sequencer;
  localparam int NSAMP = 8, DW = 8, TICK_DIV = 4, WAIT_MAX = 8;
  localparam logic [7:0] DEF [8] = '{8'h00, 8'h9D, 8'hB5, 8'h76, 8'hA6, 8'hB5, 8'hBD, 8'h75};

  logic CLK100MHZ = 0, CPU_RESETN = 1, start = 0, cfg_we = 0;
  logic [2:0] cfg_addr = 0;
  logic [DW-1:0] cfg_data = 0;
  logic busy, done, timeout_err;
  logic [7:0] LED;

  delta_frame_sequencer_if #(.DW(DW)) bus();
  delta_frame_sequencer #(.NSAMP(NSAMP), .DW(DW), .TICK_DIV(TICK_DIV), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .start(start), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bus(bus.master), .busy(busy), .done(done),
    .timeout_err(timeout_err), .LED(LED)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int checks = 0, errors = 0, nframes = 0, stalls = 0, enc_k = 0;
  int dly [8], stl [8];
  logic [7:0] mdl [8];
  logic [7:0] exp_smp [$];
  logic [8:0] exp_frm [$];
  int pend, sl, hs_n, n0, lat;
  bit seen;
  logic pbit, prev_done;
  logic [8:0] ef;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge CLK100MHZ);
    #1;
  endtask

  task automatic set_plain();
    for (int i = 0; i < 8; i++) begin dly[i] = 1; stl[i] = 0; end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d, input bit acc);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick_n(1);
    cfg_we = 0;
    if (acc) mdl[a] = d;
  endtask

  task automatic begin_frame();
    logic [7:0] led = 0;
    logic te = 0;
    for (int i = 0; i < NSAMP; i++) begin
      exp_smp.push_back(mdl[i]);
      led[i] = dly[i] != 0 && mdl[i][7];
      te |= dly[i] == 0;
    end
    exp_frm.push_back({te, led});
    start = 1;
  endtask

  task automatic wait_frame(input int f0);
    for (int c = 0; c < 1500 && nframes == f0; c++) @(negedge CLK100MHZ);
    #1;
    chk("frame_count", nframes, f0 + 1);
  endtask

  task automatic run_frame();
    int f0 = nframes;
    begin_frame();
    tick_n(1);
    start = 0;
    wait_frame(f0);
    tick_n(2);
  endtask

  // encoder model: optional ready stall per sample, returns sample MSB dly[k] cycles after handshake
  initial begin
    pend = 0; sl = 0; seen = 0; pbit = 0;
    bus.smp_ready = 1; bus.bit_valid = 0; bus.bit_in = 0;
    forever begin
      @(negedge CLK100MHZ); #1;
      if (!CPU_RESETN) begin
        enc_k = 0; pend = 0; seen = 0; bus.bit_valid = 0; bus.smp_ready = 1;
      end else begin
        bus.bit_valid = pend == 1;
        bus.bit_in = pbit;
        if (pend > 0) pend--;
        if (bus.smp_valid && !seen) begin seen = 1; sl = stl[enc_k]; end
        bus.smp_ready = !(bus.smp_valid && sl > 0);
        if (!bus.smp_ready) sl--;
        if (bus.smp_valid && bus.smp_ready) begin
          pbit = bus.smp_data[DW-1];
          pend = dly[enc_k];
          enc_k = (enc_k + 1) % NSAMP;
          seen = 0;
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a sample or a finished frame
  initial begin
    hs_n = 0; prev_done = 0;
    forever begin
      @(negedge CLK100MHZ); #2;
      if (!CPU_RESETN) begin
        hs_n = 0; prev_done = 0;
      end else begin
        if (bus.smp_valid) begin
          if (exp_smp.size() == 0) begin
            checks++; errors++;
            $display("FAIL smp_unexpected: got %0h expected no sample", bus.smp_data);
          end else if (bus.smp_ready) begin
            chk("smp_data", bus.smp_data, exp_smp.pop_front());
            hs_n++;
          end else begin
            chk("smp_hold", bus.smp_data, exp_smp[0]);
            stalls++;
          end
        end
        if (done) begin
          chk("done_pulse", prev_done, 0);
          if (exp_frm.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_unexpected: got LED %0h expected no frame", LED);
          end else begin
            ef = exp_frm.pop_front();
            chk("LED", LED, ef[7:0]);
            chk("timeout_err", timeout_err, ef[8]);
            chk("busy_at_done", busy, 0);
            chk("hs_count", hs_n, NSAMP);
          end
          hs_n = 0;
          nframes++;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = DEF[i];
    set_plain();
    #1 CPU_RESETN = 0;
    #2;
    chk("rst_smp_valid", bus.smp_valid, 0);
    chk("rst_smp_data", bus.smp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_LED", LED, 0);
    tick_n(2);
    CPU_RESETN = 1;
    tick_n(2);

    n0 = nframes;
    begin_frame();
    lat = 0;
    while (!bus.smp_valid && lat < 50) begin @(negedge CLK100MHZ); #2; lat++; end
    chk("first_valid_latency", lat, TICK_DIV + 2);
    tick_n(1);
    start = 0;
    wait_frame(n0);
    tick_n(2);
    chk("led_default", LED, 8'h76);

    stl[2] = 5;
    lat = stalls;
    run_frame();
    chk("stall_cycles", stalls - lat, 5);
    chk("led_backpressure", LED, 8'h76);
    stl[2] = 0;

    dly[1] = 0;
    run_frame();
    chk("led_timeout", LED, 8'h74);
    chk("terr_sticky", timeout_err, 1);
    dly[1] = 1;
    n0 = nframes;
    begin_frame();
    tick_n(1);
    start = 0;
    tick_n(2);
    chk("terr_cleared", timeout_err, 0);
    chk("busy_running", busy, 1);
    wait_frame(n0);
    tick_n(2);

    cfg_write(3'd3, 8'hFF, 1);
    cfg_write(3'd0, 8'h80, 1);
    n0 = nframes;
    begin_frame();
    tick_n(1);
    start = 0;
    tick_n(8);
    cfg_write(3'd5, 8'h00, 0);
    wait_frame(n0);
    tick_n(2);
    chk("led_cfg", LED, 8'h7F);

    n0 = nframes;
    begin_frame();
    tick_n(1);
    start = 0;
    tick_n(15);
    start = 1;
    wait_frame(n0);
    tick_n(60);
    chk("no_retrigger", nframes, n0 + 1);
    chk("idle_after_hold", busy, 0);
    start = 0;
    tick_n(2);

    dly[4] = WAIT_MAX;
    run_frame();
    chk("led_collision", LED, 8'h7F);
    chk("terr_collision", timeout_err, 0);
    dly[4] = 1;

    dly[5] = 0;
    begin_frame();
    tick_n(1);
    start = 0;
    for (int c = 0; c < 500 && enc_k != 6; c++) tick_n(1);
    chk("reached_sample5", enc_k, 6);
    tick_n(3);
    CPU_RESETN = 0;
    #1;
    chk("mid_rst_smp_valid", bus.smp_valid, 0);
    chk("mid_rst_smp_data", bus.smp_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_LED", LED, 0);
    exp_smp.delete();
    exp_frm.delete();
    tick_n(2);
    CPU_RESETN = 1;
    for (int i = 0; i < 8; i++) mdl[i] = DEF[i];
    dly[5] = 1;
    tick_n(2);
    run_frame();
    chk("led_after_reset", LED, 8'h76);

    repeat (6) begin
      for (int i = 0; i < NSAMP; i++) begin
        dly[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, WAIT_MAX));
        stl[i] = int'($urandom_range(0, 3));
      end
      cfg_write(3'($urandom_range(0, 7)), 8'($urandom), 1);
      cfg_write(3'($urandom_range(0, 7)), 8'($urandom), 1);
      run_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
